imm_narrow: RTL and testbench
=============================

# imm_narrow

Immediate narrowing unit: the encode-side counterpart of the datapath's 15→32-bit immediate sign extension. It accepts 32-bit signed values over a valid/ready stream and checks whether each one is representable as a 15-bit signed immediate. It emits the 15-bit field with an overflow flag, wrapping or saturating the result as selected. It sits between the assembler/loader path and instruction-word packing, and keeps a saturating count of overflowed values.

## Interface
Parameters:
- `IN_W`, 32, input operand width
- `OUT_W`, 15, immediate field width; the sign bit is `OUT_W-1`
- `CNT_W`, 16, overflow counter width

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  input word valid
- `in_ready`  out  1  unit can accept a word; driven from a register
- `in_data`  in  IN_W  signed operand
- `sat_en`  in  1  sampled with `in_data`: 1 = saturate on overflow, 0 = wrap (truncate)
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_imm`  out  OUT_W  narrowed immediate
- `out_ovf`  out  1  operand was not representable in OUT_W signed bits
- `clr_count`  in  1  clear overflow counter
- `ovf_count`  out  CNT_W  saturating count of accepted overflowed operands

## Operation
- Accept a word on `in_valid && in_ready`. Emit a result on `out_valid && out_ready`.
- Fit test: the word fits when `in_data[IN_W-1:OUT_W-1]` is all zeros or all ones.
- Result computation:
  - Word fits: `out_imm = in_data[OUT_W-1:0]`, `out_ovf = 0`.
  - Overflow, `sat_en = 1`: `out_imm = 0x3FFF` if `in_data[IN_W-1] = 0`, else `0x4000`. `out_ovf = 1`.
  - Overflow, `sat_en = 0`: `out_imm = in_data[OUT_W-1:0]`, `out_ovf = 1`.
- Results are computed combinationally at acceptance and stored as {imm, ovf}. The raw operand is not stored.
- Buffering: a main output register plus a one-entry skid register. The occupancy state machine has three states:
  - EMPTY: `out_valid = 0`, `in_ready = 1`. On accept, go to ONE.
  - ONE: `out_valid = 1`, `in_ready = 1`.
    - Accept without output handshake: go to TWO; the new result goes to the skid register.
    - Output handshake without accept: go to EMPTY.
    - Both: stay in ONE; the main register loads the new result.
  - TWO: `out_valid = 1`, `in_ready = 0`. On output handshake, the skid register moves to main; go to ONE.
- Ordering is strict FIFO. No result is dropped or duplicated.
- Counter:
  - Increments by 1 on each accepted word whose `ovf = 1`.
  - Saturates at `2^CNT_W-1`.
  - `clr_count` has priority: when clear and increment coincide, the counter becomes 0.
- Reset values: `out_valid = 0`, `in_ready = 1` on the first cycle after reset, `out_imm = 0`, `out_ovf = 0`, `ovf_count = 0`. The state machine returns to EMPTY. Reset mid-stream discards both buffered results.

## Timing
- Latency is 1 cycle: a word accepted at edge N is presented on `out_imm`/`out_ovf` with `out_valid = 1` after edge N.
- Throughput is 1 word/cycle while `out_ready = 1`.
- `in_ready` is registered. It deasserts the cycle after the skid register fills and reasserts the cycle after an output handshake in TWO.
- Upstream may hold `in_valid` with changing data while `in_ready = 0`. Only the data present at acceptance matters.
- `out_imm`/`out_ovf` are stable while `out_valid && !out_ready`.
- `ovf_count` updates on the edge of acceptance and is visible the following cycle.

## Structure
- Shared CPU package: `IMM_W = 15`, `WORD_W = 32`, `IMM_MAX = 15'h3FFF`, `IMM_MIN = 15'h4000`, and the typedef `narrow_res_t` = {logic [IMM_W-1:0] imm; logic ovf;}.
- Sub-module `imm_fit_check`: combinational fit test and saturate/wrap mux producing `narrow_res_t`. This lets the decoder-side tests reuse the fit test.
- The top level holds the skid/occupancy state machine and the counter.

## Test plan
- Fit cases, `out_ready = 1`:
  - `0x00001234` → `0x1234`, ovf 0.
  - `0xFFFFC000` → `0x4000`, ovf 0.
  - `0x00003FFF` → `0x3FFF`, ovf 0.
  - Each result appears 1 cycle after acceptance.
- Overflow, `0x00004000`:
  - `sat_en = 1` → `0x3FFF`, ovf 1.
  - `sat_en = 0` → `0x4000`, ovf 1.
  - `0xFFFFBFFF` with `sat_en = 1` → `0x4000`, ovf 1.
  - `ovf_count` = 3 after these three words.
- Backpressure: stream 1,2,3,4,5 back-to-back with `out_ready = 0` for 3 cycles.
  - `in_ready` drops after 2 words are held.
  - Outputs emerge as 1..5 in order with no loss.
  - Full throughput resumes once `out_ready = 1`.
- Counter:
  - Preload to `0xFFFE` via 65534 overflows (or force); two more overflows → `0xFFFF`, held.
  - `clr_count` coinciding with an overflow accept → 0.
- Reset mid-operation in state TWO: `rst` high for 1 cycle.
  - Next cycle: `out_valid = 0`, `in_ready = 1`, `ovf_count = 0`.
  - The next accepted `0x00000007` outputs `0x0007` as the first result.

Source files
------------

// File: rtl/imm_narrow_pkg.sv
// Shared immediate-field definitions for the narrowing unit and the decoder-side fit test.
package imm_narrow_pkg;

  localparam int IMM_W  = 15;
  localparam int WORD_W = 32;

  localparam logic [IMM_W-1:0] IMM_MAX = 15'h3FFF;
  localparam logic [IMM_W-1:0] IMM_MIN = 15'h4000;

  typedef struct packed {
    logic [IMM_W-1:0] imm;
    logic             ovf;
  } narrow_res_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/imm_fit_check.sv
// Combinational fit test for a 15-bit signed immediate plus the saturate/wrap result mux.
module imm_fit_check
  import imm_narrow_pkg::*;
(
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_sat_en,
  output narrow_res_t       o_res
);

  // The word fits when every bit from the immediate sign bit upward agrees.
  logic [WORD_W-IMM_W:0] w_upper;
  logic                  w_fits;

  assign w_upper = i_data[WORD_W-1:IMM_W-1];
  assign w_fits  = (&w_upper) | ~(|w_upper);

  always_comb begin
    o_res.ovf = ~w_fits;
    o_res.imm = i_data[IMM_W-1:0];
    if (!w_fits && i_sat_en) begin
      o_res.imm = i_data[WORD_W-1] ? IMM_MIN : IMM_MAX;
    end
  end

endmodule

// File: rtl/imm_narrow.sv
// Immediate narrowing unit: fit check at acceptance, two-entry skid buffer, saturating overflow count.
//
// state   | meaning
// S_EMPTY | no result held; out_valid=0, in_ready=1
// S_ONE   | result in main register; out_valid=1, in_ready=1
// S_TWO   | main and skid registers full; out_valid=1, in_ready=0
module imm_narrow
  import imm_narrow_pkg::*;
#(
  parameter int IN_W  = WORD_W,
  parameter int OUT_W = IMM_W,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [IN_W-1:0]  i_in_data,
  input  logic             i_sat_en,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [OUT_W-1:0] o_out_imm,
  output logic             o_out_ovf,
  input  logic             i_clr_count,
  output logic [CNT_W-1:0] o_ovf_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  occ_state_t       r_state;
  narrow_res_t      r_main;
  narrow_res_t      r_skid;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_count;

  narrow_res_t w_res;
  logic        w_acc;
  logic        w_pop;

  imm_fit_check u_fit (
    .i_data   (i_in_data),
    .i_sat_en (i_sat_en),
    .o_res    (w_res)
  );

  assign w_acc = i_in_valid & r_in_ready;
  assign w_pop = r_out_valid & i_out_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            r_main      <= w_res;
            r_out_valid <= 1'b1;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_acc && !w_pop) begin
            r_skid     <= w_res;
            r_in_ready <= 1'b0;
            r_state    <= S_TWO;
          end else if (w_pop && !w_acc) begin
            r_out_valid <= 1'b0;
            r_state     <= S_EMPTY;
          end else if (w_acc && w_pop) begin
            r_main <= w_res;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= S_ONE;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Clear wins over a coincident overflow increment.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr_count) begin
      r_count <= '0;
    end else if (w_acc && w_res.ovf && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_imm   = r_main.imm;
  assign o_out_ovf   = r_main.ovf;
  assign o_ovf_count = r_count;

endmodule

// File: tb/tb_imm_narrow.sv
// Self-checking bench for imm_narrow against a value-range reference model and FIFO scoreboard.
module tb_imm_narrow;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        sat_en;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_imm;
  logic        out_ovf;
  logic        clr_count;
  logic [15:0] ovf_count;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  imm_narrow dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .i_sat_en    (sat_en),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_imm   (out_imm),
    .o_out_ovf   (out_ovf),
    .i_clr_count (clr_count),
    .o_ovf_count (ovf_count)
  );

  // Reference: representable range of a 15-bit signed field is -16384..16383.
  function automatic logic [15:0] model(input logic [31:0] d, input logic s);
    int v;
    v = int'($signed(d));
    if (v >= -16384 && v <= 16383) return {d[14:0], 1'b0};
    if (s) return {(v < 0) ? 15'h4000 : 15'h3FFF, 1'b1};
    return {d[14:0], 1'b1};
  endfunction

  function automatic logic [31:0] pick_data();
    int k;
    int b;
    k = $urandom_range(0, 3);
    case (k)
      0: return $urandom;
      1: return 32'($urandom_range(0, 65535)) - 32'd32768;
      2: begin
        b = $urandom_range(0, 3);
        case (b)
          0: return 32'd16383;
          1: return 32'd16384;
          2: return 32'hFFFFC000;
          default: return 32'hFFFFBFFF;
        endcase
      end
      default: return 32'hFFFF0000 | 32'($urandom_range(0, 65535));
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; sat_en = 1'b0;
    out_ready = 1'b0; clr_count = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if ({out_imm, out_ovf} !== 16'h0) begin failures++; $display("FAIL reset_out got=%h exp=0", {out_imm, out_ovf}); end
    checks++; if (ovf_count !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", ovf_count); end
    exp_q.delete();
    exp_cnt = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single(input string name, input logic [31:0] d, input logic s,
                             input logic [14:0] e_imm, input logic e_ovf);
    in_valid = 1'b1; in_data = d; sat_en = s; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL %s_pre got=valid%b/ready%b exp=valid0/ready1", name, out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = $urandom;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL %s_latency got=%b exp=1", name, out_valid); end
    checks++; if ({out_imm, out_ovf} !== {e_imm, e_ovf}) begin
      failures++; $display("FAIL %s_value got=%h/%b exp=%h/%b", name, out_imm, out_ovf, e_imm, e_ovf);
    end
    checks++; if ({out_imm, out_ovf} !== model(d, s)) begin
      failures++; $display("FAIL %s_model got=%h exp=%h", name, {out_imm, out_ovf}, model(d, s));
    end
    if (e_ovf) exp_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_fit();
    test_single("fit_1234", 32'h00001234, 1'b1, 15'h1234, 1'b0);
    test_single("fit_min",  32'hFFFFC000, 1'b1, 15'h4000, 1'b0);
    test_single("fit_max",  32'h00003FFF, 1'b0, 15'h3FFF, 1'b0);
  endtask

  task automatic test_overflow();
    test_single("ovf_pos_sat",  32'h00004000, 1'b1, 15'h3FFF, 1'b1);
    test_single("ovf_pos_wrap", 32'h00004000, 1'b0, 15'h4000, 1'b1);
    test_single("ovf_neg_sat",  32'hFFFFBFFF, 1'b1, 15'h4000, 1'b1);
    @(negedge clk);
    checks++; if (ovf_count !== 16'd3) begin failures++; $display("FAIL ovf_count3 got=%0d exp=3", ovf_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int pops = 0;
    int last_pop = -1;
    logic [15:0] e;
    for (int c = 0; c < 20; c++) begin
      in_valid = (idx < 5); in_data = 32'(idx + 1); sat_en = 1'b1;
      out_ready = (c >= 3); clr_count = 1'b0;
      @(negedge clk);
      if (c == 2) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_drop got=%b exp=0", in_ready); end
      end
      checks++; if (in_ready !== (exp_q.size() < 2)) begin
        failures++; $display("FAIL bp_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_q.size() < 2);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL bp_extra got=%h exp=none", {out_imm, out_ovf}); end
        else begin
          e = exp_q.pop_front();
          if ({out_imm, out_ovf} !== e) begin failures++; $display("FAIL bp_order got=%h exp=%h", {out_imm, out_ovf}, e); end
        end
        pops++; last_pop = c;
      end
      if (in_valid && in_ready) begin exp_q.push_back(model(in_data, sat_en)); idx++; end
      @(posedge clk); #1;
    end
    checks++; if (pops !== 5) begin failures++; $display("FAIL bp_count got=%0d exp=5", pops); end
    checks++; if (last_pop !== 7) begin failures++; $display("FAIL bp_throughput last_pop got=%0d exp=7", last_pop); end
  endtask

  task automatic test_random();
    logic [15:0] e;
    int n = 500;
    for (int c = 0; c < n; c++) begin
      if (c < n - 4) begin
        in_valid = ($urandom_range(0, 3) != 0); in_data = pick_data(); sat_en = 1'($urandom);
        out_ready = ($urandom_range(0, 3) != 0); clr_count = ($urandom_range(0, 49) == 0);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
      end
      @(negedge clk);
      checks++; if (ovf_count !== 16'(exp_cnt)) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d", ovf_count, exp_cnt); end
      checks++; if (out_valid !== (exp_q.size() != 0) || in_ready !== (exp_q.size() < 2)) begin
        failures++; $display("FAIL rnd_flags got=valid%b/ready%b exp_depth=%0d", out_valid, in_ready, exp_q.size());
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++; if ({out_imm, out_ovf} !== e) begin failures++; $display("FAIL rnd_data got=%h exp=%h", {out_imm, out_ovf}, e); end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data, sat_en));
      if (clr_count) exp_cnt = 0;
      else if (in_valid && in_ready && model(in_data, sat_en)[0] && exp_cnt < 65535) exp_cnt++;
      @(posedge clk); #1;
    end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL rnd_drain got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_counter_sat();
    in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0; in_valid = 1'b1; in_data = 32'h00004000; sat_en = 1'b1;
    repeat (65534) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++; if (ovf_count !== 16'hFFFE) begin failures++; $display("FAIL cnt_preload got=%h exp=fffe", ovf_count); end
    @(posedge clk); #1 in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++; if (ovf_count !== 16'hFFFF) begin failures++; $display("FAIL cnt_sat got=%h exp=ffff", ovf_count); end
    @(posedge clk); #1 in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++; if (ovf_count !== 16'hFFFF) begin failures++; $display("FAIL cnt_hold got=%h exp=ffff", ovf_count); end
    @(posedge clk); #1 in_valid = 1'b1; clr_count = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; clr_count = 1'b0;
    @(negedge clk);
    checks++; if (ovf_count !== 16'h0) begin failures++; $display("FAIL cnt_clr_prio got=%h exp=0", ovf_count); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h00004000; sat_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL mid_two got=valid%b/ready%b exp=valid1/ready0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL mid_rst_flags got=valid%b/ready%b exp=valid0/ready1", out_valid, in_ready);
    end
    checks++; if (ovf_count !== 16'h0) begin failures++; $display("FAIL mid_rst_count got=%h exp=0", ovf_count); end
    in_valid = 1'b1; in_data = 32'h00000007; sat_en = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || {out_imm, out_ovf} !== {15'h0007, 1'b0}) begin
      failures++; $display("FAIL mid_first got=valid%b/%h/%b exp=valid1/0007/0", out_valid, out_imm, out_ovf);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_fit();
    test_overflow();
    test_backpressure();
    test_random();
    test_counter_sat();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
